// File: rtl/mdio_master_mb_if.sv
// Host-side command/response channel of the MDIO management master.
//   master modport : host side (drives cmd_*, rsp_ready)
//   slave modport  : mdio_master_mb side (drives cmd_ready, rsp_*)
// Signals:
//   cmd_bus/cmd_c45/cmd_opcode/cmd_phy_addr/cmd_reg_addr/cmd_data/
//   cmd_no_preamble : command fields, qualified by cmd_valid
//   cmd_valid/cmd_ready : command handshake
//   rsp_data/rsp_error  : read response payload, qualified by rsp_valid
//   rsp_valid/rsp_ready : response handshake
interface mdio_master_mb_if #(
  parameter int BUS_W = 1
);
  logic [BUS_W-1:0] cmd_bus;
  logic             cmd_c45;
  logic [1:0]       cmd_opcode;
  logic [4:0]       cmd_phy_addr;
  logic [4:0]       cmd_reg_addr;
  logic [15:0]      cmd_data;
  logic             cmd_no_preamble;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      rsp_data;
  logic             rsp_error;
  logic             rsp_valid;
  logic             rsp_ready;

  modport master (
    output cmd_bus, cmd_c45, cmd_opcode, cmd_phy_addr, cmd_reg_addr,
           cmd_data, cmd_no_preamble, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_data, rsp_error, rsp_valid
  );

  modport slave (
    input  cmd_bus, cmd_c45, cmd_opcode, cmd_phy_addr, cmd_reg_addr,
           cmd_data, cmd_no_preamble, cmd_valid, rsp_ready,
    output cmd_ready, rsp_data, rsp_error, rsp_valid
  );
endinterface

// File: rtl/mdio_master_mb.sv
// Multi-bus MDIO management master (Clause 22 and Clause 45 frames).
// Serialises one management transaction at a time onto one of N_BUSES
// MDC/MDIO pin pairs and returns read data on a valid/ready channel.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   host        : command/response channel (slave modport)
//   mdc_o       : MDC per bus
//   mdio_i      : MDIO input per bus
//   mdio_o      : MDIO output per bus
//   mdio_t      : MDIO tristate per bus, 1 = released
//   busy        : transaction in progress on the pins
//   prescale    : MDC half-period minus one, latched at accept
module mdio_master_mb #(
  parameter int N_BUSES      = 1,
  parameter int BUS_W        = (N_BUSES > 1) ? $clog2(N_BUSES) : 1,
  parameter int PRESCALE_W   = 8,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mdio_master_mb_if.slave       host,
  output logic [N_BUSES-1:0]    mdc_o,
  input  logic [N_BUSES-1:0]    mdio_i,
  output logic [N_BUSES-1:0]    mdio_o,
  output logic [N_BUSES-1:0]    mdio_t,
  output logic                  busy,
  input  logic [PRESCALE_W-1:0] prescale
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_FRAME    = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Builds the 32-bit management frame {ST, OP, PHYAD, REGAD, TA, DATA}.
  function automatic logic [31:0] frame_word(input logic c45, input logic [1:0] op,
                                             input logic [4:0] phy, input logic [4:0] regad,
                                             input logic [15:0] data);
    logic [1:0] st;
    if (c45) st = 2'b00;
    else     st = 2'b01;
    return {st, op, phy, regad, 2'b10, data};
  endfunction

  // Frame bit idx (1..32, MSB first) of a frame word.
  function automatic logic frame_bit(input logic [31:0] frame, input logic [5:0] idx);
    return frame[5'(6'd32 - idx)];
  endfunction

  // Reads release the line from the first turnaround bit to the end.
  function automatic logic frame_release(input logic rd, input logic [5:0] idx);
    return rd & (idx >= 6'd15);
  endfunction

  logic [1:0]            state_r;
  logic [5:0]            bit_r;
  logic [PRESCALE_W-1:0] cnt_r;
  logic [PRESCALE_W-1:0] p_r;
  logic                  high_r;
  logic [31:0]           frame_r;
  logic                  read_r;
  logic [BUS_W-1:0]      bus_r;
  logic                  sync_r;
  logic [15:0]           shift_r;
  logic                  err_r;
  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic [15:0]           rsp_data_r;
  logic                  rsp_error_r;
  logic                  busy_r;
  logic [N_BUSES-1:0]    mdc_r;
  logic [N_BUSES-1:0]    mdio_o_r;
  logic [N_BUSES-1:0]    mdio_t_r;

  logic                  fire_s;
  logic                  cmd_read_s;
  logic                  cmd_bus_ok_s;
  logic [31:0]           cmd_frame_s;
  logic [N_BUSES-1:0]    cmd_mask_s;
  logic [N_BUSES-1:0]    sel_mask_s;
  logic                  mdio_sel_s;
  logic [5:0]            next_bit_s;
  logic                  next_o_s;
  logic                  next_t_s;

  assign fire_s       = host.cmd_valid & cmd_ready_r;
  assign cmd_read_s   = host.cmd_opcode[1];
  assign cmd_frame_s  = frame_word(host.cmd_c45, host.cmd_opcode, host.cmd_phy_addr,
                                   host.cmd_reg_addr, host.cmd_data);
  assign cmd_bus_ok_s = |cmd_mask_s;
  assign next_bit_s   = bit_r + 6'd1;
  assign next_o_s     = frame_bit(frame_r, next_bit_s);
  assign next_t_s     = frame_release(read_r, next_bit_s);

  // Decode bus masks for the incoming and the latched bus index, and pick
  // the selected MDIO input; out-of-range indices select nothing.
  always_comb begin
    cmd_mask_s = '0;
    sel_mask_s = '0;
    mdio_sel_s = 1'b1;
    for (int i = 0; i < N_BUSES; i++) begin
      cmd_mask_s[i] = (host.cmd_bus == BUS_W'(i));
      if (bus_r == BUS_W'(i)) begin
        sel_mask_s[i] = 1'b1;
        mdio_sel_s    = mdio_i[i];
      end else begin
        sel_mask_s[i] = 1'b0;
      end
    end
  end

  // Transaction sequencer: command accept, bit timing, sampling, response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_r       <= 6'd0;
      cnt_r       <= '0;
      p_r         <= '0;
      high_r      <= 1'b0;
      frame_r     <= 32'd0;
      read_r      <= 1'b0;
      bus_r       <= '0;
      sync_r      <= 1'b1;
      shift_r     <= 16'd0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'd0;
      rsp_error_r <= 1'b0;
      busy_r      <= 1'b0;
      mdc_r       <= '0;
      mdio_o_r    <= '0;
      mdio_t_r    <= '1;
    end else begin
      sync_r <= mdio_sel_s;
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            cmd_ready_r <= 1'b0;
            p_r         <= prescale;
            frame_r     <= cmd_frame_s;
            read_r      <= cmd_read_s;
            bus_r       <= host.cmd_bus;
            cnt_r       <= '0;
            high_r      <= 1'b0;
            bit_r       <= 6'd1;
            if (!cmd_bus_ok_s) begin
              // No such bus: reads fail immediately, writes vanish.
              if (cmd_read_s) begin
                state_r     <= ST_RESP;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= 16'hFFFF;
                rsp_error_r <= 1'b1;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              busy_r <= 1'b1;
              mdc_r  <= '0;
              if (host.cmd_no_preamble) begin
                state_r  <= ST_FRAME;
                mdio_o_r <= cmd_mask_s & {N_BUSES{cmd_frame_s[31]}};
                mdio_t_r <= ~cmd_mask_s;
              end else begin
                state_r  <= ST_PREAMBLE;
                mdio_o_r <= cmd_mask_s;
                mdio_t_r <= ~cmd_mask_s;
              end
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end

        ST_PREAMBLE, ST_FRAME: begin
          if (cnt_r != p_r) begin
            cnt_r <= cnt_r + 1'b1;
          end else begin
            cnt_r <= '0;
            if (!high_r) begin
              high_r <= 1'b1;
              mdc_r  <= sel_mask_s;
            end else begin
              // End of a high half: sample, then launch the next bit.
              high_r <= 1'b0;
              mdc_r  <= '0;
              if (state_r == ST_PREAMBLE) begin
                if (bit_r == 6'(PREAMBLE_LEN)) begin
                  state_r  <= ST_FRAME;
                  bit_r    <= 6'd1;
                  mdio_o_r <= sel_mask_s & {N_BUSES{frame_r[31]}};
                  mdio_t_r <= ~sel_mask_s;
                end else begin
                  bit_r    <= next_bit_s;
                  mdio_o_r <= sel_mask_s;
                  mdio_t_r <= ~sel_mask_s;
                end
              end else begin
                if (bit_r == 6'd16) begin
                  err_r <= sync_r;
                end else if (bit_r >= 6'd17) begin
                  shift_r <= {shift_r[14:0], sync_r};
                end else begin
                  err_r <= err_r;
                end
                if (bit_r == 6'd32) begin
                  busy_r   <= 1'b0;
                  mdio_o_r <= '0;
                  mdio_t_r <= '1;
                  if (read_r) begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= {shift_r[14:0], sync_r};
                    rsp_error_r <= err_r;
                  end else begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                  end
                end else begin
                  bit_r    <= next_bit_s;
                  mdio_o_r <= sel_mask_s & {N_BUSES{next_o_s & ~next_t_s}};
                  mdio_t_r <= ~sel_mask_s | {N_BUSES{next_t_s}};
                end
              end
            end
          end
        end

        ST_RESP: begin
          if (host.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          mdc_r       <= '0;
          mdio_o_r    <= '0;
          mdio_t_r    <= '1;
        end
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_r;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_data  = rsp_data_r;
  assign host.rsp_error = rsp_error_r;
  assign busy           = busy_r;
  assign mdc_o          = mdc_r;
  assign mdio_o         = mdio_o_r;
  assign mdio_t         = mdio_t_r;

endmodule

// File: tb/tb_mdio_master_mb.sv
// Self-checking bench for mdio_master_mb: directed scenarios plus random
// transactions, checked against a frame/timing model built from field values.
module tb_mdio_master_mb;
  localparam int NB  = 5;
  localparam int BW  = 3;
  localparam int PRE = 32;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] mdc_o;
  logic [NB-1:0] mdio_i;
  logic [NB-1:0] mdio_o;
  logic [NB-1:0] mdio_t;
  logic          busy;
  logic [7:0]    prescale;

  int checks = 0;
  int errors = 0;

  mdio_master_mb_if #(.BUS_W(BW)) host ();

  mdio_master_mb #(.N_BUSES(NB), .BUS_W(BW), .PRESCALE_W(8), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .host(host), .mdc_o(mdc_o), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .busy(busy), .prescale(prescale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one command, plays the PHY, and checks stream, timing and response.
  task automatic run_cmd(input logic [2:0] bus, input logic c45, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] rega, input logic [15:0] data,
                         input logic nopre, input int p, input logic [15:0] phy_data,
                         input logic ta2, input int hold);
    int busi, bbits, exp_done, cyc, n, rises, falls, nb, other_act, busy_bad, spur, unstable;
    logic rd, ok, done;
    logic [31:0] frm;
    logic [63:0] o_got, t_got, o_exp, t_exp;
    logic [NB-1:0] prev_mdc;
    logic [15:0] data_ref;
    busi  = int'(bus);
    rd    = op[1];
    ok    = (busi < NB);
    frm   = {(c45 ? 2'b00 : 2'b01), op, phy, rega, 2'b10, data};
    bbits = (nopre ? 0 : PRE) + 32;
    exp_done = ok ? bbits * 2 * (p + 1) + 1 : 2;
    o_exp = nopre ? {32'd0, frm} : {32'hFFFF_FFFF, frm};
    t_exp = rd ? 64'h3FFFF : 64'd0;

    n = 0;
    while (!host.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", 64'(host.cmd_ready), 64'd1);

    host.cmd_bus = bus; host.cmd_c45 = c45; host.cmd_opcode = op;
    host.cmd_phy_addr = phy; host.cmd_reg_addr = rega; host.cmd_data = data;
    host.cmd_no_preamble = nopre; host.cmd_valid = 1'b1;
    prescale = 8'(p);
    mdio_i   = '1;
    prev_mdc = mdc_o;
    cyc = 0; done = 1'b0; rises = 0; falls = 0; other_act = 0; busy_bad = 0; spur = 0;
    o_got = 64'd0; t_got = 64'd0;

    while (!done && cyc < exp_done + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        host.cmd_valid = 1'b0;
        prescale = 8'($urandom_range(0, 255));
        check("ready_drop", 64'(host.cmd_ready), 64'd0);
      end
      for (int i = 0; i < NB; i++) begin
        if (i != busi && (mdc_o[i] || mdio_o[i] || !mdio_t[i])) other_act++;
      end
      if (busy !== (ok && cyc < exp_done)) busy_bad++;
      if (ok) begin
        if (mdc_o[busi] && !prev_mdc[busi]) begin
          o_got = {o_got[62:0], mdio_o[busi]};
          t_got = {t_got[62:0], mdio_t[busi]};
          rises++;
        end
        if (!mdc_o[busi] && prev_mdc[busi]) begin
          falls++;
          nb = falls + 1 - (nopre ? 0 : PRE);
          if (nb == 16)      mdio_i[busi] = ta2;
          else if (nb >= 17) mdio_i[busi] = phy_data[32 - nb];
          else               mdio_i[busi] = 1'b1;
        end
      end
      prev_mdc = mdc_o;
      if (!rd && host.rsp_valid) spur++;
      if (rd ? host.rsp_valid : (host.cmd_ready && cyc > 1)) done = 1'b1;
    end

    check("done", 64'(done), 64'd1);
    check("others_idle", 64'(other_act), 64'd0);
    check("busy_window", 64'(busy_bad), 64'd0);
    if (ok) begin
      check("done_cycle", 64'(cyc), 64'(exp_done));
      check("bit_count", 64'(rises), 64'(bbits));
      check("stream_t", t_got, t_exp);
      check("stream_o", o_got & ~t_exp, o_exp & ~t_exp);
      check("pins_after", {54'd0, mdc_o, mdio_t}, {54'd0, 5'd0, 5'h1F});
    end else begin
      check("no_mdc_bad_bus", 64'(rises), 64'd0);
    end
    if (!rd) begin
      check("no_rsp_write", 64'(spur), 64'd0);
    end else begin
      check("rsp_data", 64'(host.rsp_data), 64'(ok ? phy_data : 16'hFFFF));
      check("rsp_error", 64'(host.rsp_error), 64'(ok ? ta2 : 1'b1));
      check("ready_in_resp", 64'(host.cmd_ready), 64'd0);
      data_ref = host.rsp_data;
      unstable = 0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!host.rsp_valid || host.rsp_data !== data_ref || host.cmd_ready) unstable++;
      end
      check("resp_hold", 64'(unstable), 64'd0);
      host.rsp_ready = 1'b1;
      @(negedge clk);
      host.rsp_ready = 1'b0;
      check("rsp_release", {62'd0, host.rsp_valid, host.cmd_ready}, 64'd1);
    end
  endtask

  initial begin
    int n, rises;
    logic [NB-1:0] prev;
    rst_n = 1'b0; prescale = 8'd0; mdio_i = '1;
    host.cmd_bus = '0; host.cmd_c45 = 1'b0; host.cmd_opcode = 2'b00;
    host.cmd_phy_addr = 5'd0; host.cmd_reg_addr = 5'd0; host.cmd_data = 16'd0;
    host.cmd_no_preamble = 1'b0; host.cmd_valid = 1'b0; host.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(host.cmd_ready), 64'd0);
    check("rst_rsp", {45'd0, host.rsp_valid, host.rsp_error, host.rsp_data, busy}, 64'd0);
    check("rst_pins", {49'd0, mdc_o, mdio_o, mdio_t}, {49'd0, 5'd0, 5'd0, 5'h1F});
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(host.cmd_ready), 64'd1);

    // Clause 22 write with preamble, P=1.
    run_cmd(3'd0, 1'b0, 2'b01, 5'd3, 5'h04, 16'h01E1, 1'b0, 1, 16'h0, 1'b0, 0);
    // Clause 45 read without preamble, P=0, bus 2.
    run_cmd(3'd2, 1'b1, 2'b11, 5'd7, 5'd1, 16'h0000, 1'b1, 0, 16'hBEEF, 1'b0, 2);
    // Clause 22 read with no PHY answering.
    run_cmd(3'd1, 1'b0, 2'b10, 5'd9, 5'd2, 16'h1234, 1'b0, 0, 16'hFFFF, 1'b1, 0);
    // Read and write on a bus that does not exist.
    run_cmd(3'd5, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b1, 0, 16'h0, 1'b0, 1);
    run_cmd(3'd7, 1'b1, 2'b01, 5'd1, 5'd1, 16'hA5A5, 1'b1, 0, 16'h0, 1'b0, 0);
    // Long response back-pressure.
    run_cmd(3'd4, 1'b0, 2'b10, 5'd2, 5'd5, 16'h0, 1'b1, 1, 16'h5A3C, 1'b0, 20);

    // Reset during frame bit 10, then a normal write.
    n = 0;
    while (!host.cmd_ready && n < 50) begin @(negedge clk); n++; end
    host.cmd_bus = 3'd1; host.cmd_c45 = 1'b0; host.cmd_opcode = 2'b01;
    host.cmd_no_preamble = 1'b1; host.cmd_valid = 1'b1; prescale = 8'd1;
    prev = mdc_o; rises = 0; n = 0;
    while (rises < 10 && n < 500) begin
      @(negedge clk);
      n++;
      if (n == 1) host.cmd_valid = 1'b0;
      if (mdc_o[1] && !prev[1]) rises++;
      prev = mdc_o;
    end
    check("reach_bit10", 64'(rises), 64'd10);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pins", {54'd0, mdc_o, mdio_t}, {54'd0, 5'd0, 5'h1F});
    check("midrst_ctrl", {61'd0, busy, host.rsp_valid, host.cmd_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(host.cmd_ready), 64'd1);
    run_cmd(3'd1, 1'b0, 2'b01, 5'd6, 5'd8, 16'hC0DE, 1'b0, 0, 16'h0, 1'b0, 0);

    // Random transactions, back-to-back.
    for (int t = 0; t < 12; t++) begin
      run_cmd(3'($urandom_range(0, NB - 1)), 1'($urandom), 2'($urandom),
              5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
              $urandom_range(0, 3), 16'($urandom), 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_master_mb.md
# mdio_master_mb

Multi-bus MDIO management master supporting both IEEE 802.3 Clause 22 and Clause 45 frames. It has a per-command preamble-suppression option, latches the prescale value per command, and detects a missing PHY on reads. It sits between a host control path (CSR block or soft CPU bridge) and up to N_BUSES independent MDC/MDIO pin pairs. It serialises one management transaction at a time onto the selected bus and returns read data on a valid/ready response channel.

## Interface
- N_BUSES, 1: number of MDC/MDIO pin pairs (1..8).
- BUS_W, (N_BUSES>1 ? $clog2(N_BUSES) : 1): width of cmd_bus.
- PRESCALE_W, 8: width of prescale input.
- PREAMBLE_LEN, 32: number of preamble '1' bits (1..63).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low.
- cmd_bus  in  BUS_W  target bus index.
- cmd_c45  in  1  1 = Clause 45 frame (ST=00); 0 = Clause 22 (ST=01).
- cmd_opcode  in  2  OP field. Read when cmd_opcode[1]=1 (C22 10; C45 10 post-read-inc, 11 read).
- cmd_phy_addr  in  5  PHYAD/PRTAD.
- cmd_reg_addr  in  5  REGAD/DEVAD.
- cmd_data  in  16  write data or C45 address.
- cmd_no_preamble  in  1  skip preamble for this command.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- rsp_data  out  16  read data.
- rsp_error  out  1  read failed (TA not driven low, or bad bus index).
- rsp_valid  out  1  response valid; issued for read opcodes only.
- rsp_ready  in  1  response consumed.
- mdc_o  out  N_BUSES  MDC per bus.
- mdio_i  in  N_BUSES  MDIO input per bus.
- mdio_o  out  N_BUSES  MDIO output per bus.
- mdio_t  out  N_BUSES  tristate control, 1 = released.
- busy  out  1  transaction in progress.
- prescale  in  PRESCALE_W  MDC half-period minus one, in clk cycles.

## Operation
- States: IDLE, PREAMBLE, FRAME, RESP.
- **IDLE**
  - cmd_ready = ~rsp_valid.
  - On accept, latch all cmd_* fields and prescale (P).
  - Go to PREAMBLE, or to FRAME if cmd_no_preamble.
  - cmd_bus ≥ N_BUSES: no pin activity. A read goes to RESP with rsp_data=16'hFFFF, rsp_error=1. A write is dropped and the block stays in IDLE.
- **Bit timing**
  - Each bit is a low half then a high half of MDC, each P+1 clk cycles.
  - mdio_o/mdio_t update on the first cycle of the low half.
  - mdc_o rises on the first cycle of the high half.
- **PREAMBLE**: PREAMBLE_LEN bits with mdio_o=1, mdio_t=0.
- **FRAME**: 32 bits, MSB first: {ST, OP, PHYAD, REGAD, TA=10, DATA16}.
  - For reads, mdio_t=1 from bit 15 (first TA bit) through bit 32.
- **Sampling**
  - mdio_i of the selected bus passes through one sync register.
  - It is sampled in the last cycle of each high half.
  - Read data = samples of bits 17..32.
  - rsp_error = sample of bit 16 (second TA bit) == 1.
- **After bit 32**: all mdio_t=1, mdc_o=0. A read goes to RESP (rsp_valid=1); a write goes to IDLE.
- **RESP**: rsp_valid holds, with data stable, until rsp_ready; then go to IDLE.
- **Unselected buses**: always mdc_o=0, mdio_o=0, mdio_t=1.
- **busy**: 1 from the cycle after accept until the FRAME→IDLE/RESP transition. It is 0 in RESP.

## Timing
- **Reset values**: cmd_ready=0, rsp_valid=0, rsp_error=0, rsp_data=0, mdc_o=0, mdio_o=0, mdio_t=all 1, busy=0.
- cmd_ready first rises the cycle after rst_n deasserts.
- Accept in cycle A with B = (no_preamble ? 0 : PREAMBLE_LEN) + 32:
  - First low half begins at A+1.
  - The last high half ends at A+B·2(P+1).
  - rsp_valid is high (read) or cmd_ready is high (write) at A+B·2(P+1)+1.
- cmd_ready deasserts the cycle after accept.
- A new command can be accepted in the cycle cmd_ready returns (back-to-back writes).
- rsp_valid & rsp_ready: rsp_valid drops the next cycle and cmd_ready rises that same cycle.
- rst_n low mid-frame: outputs take their reset values in the next cycle. The frame is abandoned and no response is produced.
- Changing prescale mid-transaction has no effect until the next accept.
- The bit counter is 6 bits. Frame bit indices count 1..32 with no wrap.

## Test plan
- **C22 write, P=1, bus 0, PREAMBLE_LEN=32** (phy=3, reg=0x04, data=0x01E1) → 64 MDC periods of 4 clk each. The serial stream is 32×'1' then 0101_00011_00100_10_0000000111100001. No rsp_valid. cmd_ready returns at A+257.
- **C45 read, no_preamble, P=0, bus 2 of 4**; PHY model drives TA=0 then 0xBEEF → rsp_data=0xBEEF, rsp_error=0. mdio_t[2]=1 from bit 15. Buses 0, 1, 3 stay idle. rsp_valid at A+65.
- **C22 read with mdio_i held 1** → rsp_data=0xFFFF, rsp_error=1.
- **Read with cmd_bus=5, N_BUSES=4** → no MDC edges on any bus. rsp_error=1, rsp_data=0xFFFF.
- **rsp_ready held low for 20 cycles after a read** → rsp_valid and rsp_data stable, cmd_ready=0. Both release one cycle after rsp_ready.
- **rst_n pulsed low during frame bit 10** → next cycle: all mdio_t=1, mdc_o=0, busy=0. A subsequent write completes normally.
